zorro_autoconfig_fsm: RTL and testbench

// - Zorro II autoconfig responder feeding the fastRAM DRAM controller: offers up to NUM_BLOCKS x 2MB

---
 rtl/zorro_ac_pkg.sv | 20 ++
 rtl/zorro_autoconfig_fsm_if.sv | 22 ++
 rtl/strobe_sync.sv | 26 ++
 rtl/zorro_autoconfig_fsm.sv | 162 ++++++++++++++++
 tb/tb_zorro_autoconfig_fsm.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zorro_ac_pkg.sv
// Shared types and constants for the Zorro II autoconfig responder.
package zorro_ac_pkg;

    typedef enum logic [1:0] {
        StOffer,
        StDummy,
        StDone
    } ac_state_e;

    localparam logic [7:0] AcPage  = 8'hE8;
    localparam logic [7:0] RegBase = 8'h24;
    localparam logic [7:0] RegShut = 8'h26;

    // er_type / er_size nibbles, already in their on-bus (uninverted) form
    localparam logic [3:0] ErTypeZ2    = 4'b1110;
    localparam logic [3:0] ErTypeDummy = 4'b1100;
    localparam logic [3:0] ErSize2M    = 4'b0110;
    localparam logic [3:0] ErSize64K   = 4'b0001;

endpackage

// File: rtl/zorro_autoconfig_fsm_if.sv
// 68000 bus signals seen by the autoconfig responder (data nibble D15..D12 only).
interface zorro_autoconfig_fsm_if;

    logic [23:1] ADDR;
    logic        AS_n;
    logic        UDS_n;
    logic        RW_n;
    logic [3:0]  DIN;
    logic [3:0]  DOUT;
    logic        DOE;

    modport master (
        output ADDR, AS_n, UDS_n, RW_n, DIN,
        input  DOUT, DOE
    );

    modport slave (
        input  ADDR, AS_n, UDS_n, RW_n, DIN,
        output DOUT, DOE
    );

endinterface

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for an active-low strobe with a third stage for edge detection.
module strobe_sync (
    input  logic CLK,
    input  logic reset,
    input  logic strobe_n,
    output logic sync,
    output logic fall,
    output logic rise
);

    logic [2:0] ff_q;

    // Reset to the idle (high) level so no edge is seen when reset releases
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ff_q <= 3'b111;
        end else begin
            ff_q <= {ff_q[1:0], strobe_n};
        end
    end

    assign sync = ff_q[1];
    assign fall = ff_q[2] & ~ff_q[1];
    assign rise = ~ff_q[2] & ff_q[1];

endmodule

// File: rtl/zorro_autoconfig_fsm.sv
// Zorro II autoconfig responder: offers NUM_BLOCKS x 2MB boards in turn and
// turns base-address writes into a 1MB-bank match vector for the DRAM controller.
module zorro_autoconfig_fsm
    import zorro_ac_pkg::*;
#(
    parameter logic [15:0] MFG_ID     = 16'h07DB,
    parameter logic [7:0]  PROD_ID    = 8'd59,
    parameter logic [15:0] SERIAL     = 16'd421,
    parameter int unsigned NUM_BLOCKS = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    zorro_autoconfig_fsm_if.slave  bus,
    input  logic                   CFGIN_n,
    output logic                   CFGOUT_n,
    output logic [7:0]             addr_match,
    output logic                   configured
);

    localparam logic [1:0] LastBlk = 2'(NUM_BLOCKS - 1);

    logic as_s, as_fall, as_rise;
    logic uds_s, uds_fall, uds_rise;
    logic cfgin_s, cfgin_fall, cfgin_rise;

    strobe_sync u_as_sync (
        .CLK      (CLK),
        .reset    (reset),
        .strobe_n (bus.AS_n),
        .sync     (as_s),
        .fall     (as_fall),
        .rise     (as_rise)
    );

    strobe_sync u_uds_sync (
        .CLK      (CLK),
        .reset    (reset),
        .strobe_n (bus.UDS_n),
        .sync     (uds_s),
        .fall     (uds_fall),
        .rise     (uds_rise)
    );

    strobe_sync u_cfgin_sync (
        .CLK      (CLK),
        .reset    (reset),
        .strobe_n (CFGIN_n),
        .sync     (cfgin_s),
        .fall     (cfgin_fall),
        .rise     (cfgin_rise)
    );

    ac_state_e  state_q, state_d;
    logic [1:0] blk_q, blk_d;
    logic [7:0] match_q, match_d;
    logic       cfg_q, cfg_d;
    logic       cfgout_q, cfgout_d;
    logic [3:0] dout_q, dout_d;

    logic [7:0] reg_sel;
    logic       ac_space;
    logic       wr_strobe;

    assign reg_sel   = bus.ADDR[8:1];
    assign ac_space  = (bus.ADDR[23:16] == AcPage) & ~cfgin_s & (state_q != StDone);
    // uds_s is held low by reset-released flops only after a real edge, so one strobe per cycle
    assign wr_strobe = uds_fall & ~as_s & ~bus.RW_n & ac_space;

    assign bus.DOE  = ac_space & bus.RW_n & ~as_s & ~uds_s;
    assign bus.DOUT = dout_q;

    assign CFGOUT_n   = cfgout_q;
    assign addr_match = match_q;
    assign configured = cfg_q;

    logic unused_sig;
    assign unused_sig = ^{bus.ADDR[15:9], as_fall, uds_rise, cfgin_fall, cfgin_rise};

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        match_d  = match_q;
        cfg_d    = cfg_q;
        cfgout_d = cfgout_q;

        if (wr_strobe) begin
            if (reg_sel == RegBase) begin
                if (state_q == StOffer) begin
                    // Base nibble 2/4/6/8 selects the 2MB window at $200000..$800000
                    case (bus.DIN)
                        4'd2:    match_d[1:0] = 2'b11;
                        4'd4:    match_d[3:2] = 2'b11;
                        4'd6:    match_d[5:4] = 2'b11;
                        4'd8:    match_d[7:6] = 2'b11;
                        default: ;
                    endcase
                    cfg_d = 1'b1;
                    if (blk_q == LastBlk) begin
                        state_d = StDone;
                    end else begin
                        blk_d = blk_q + 2'd1;
                    end
                end else if (state_q == StDummy) begin
                    state_d = StDone;
                end
            end else if (reg_sel == RegShut) begin
                if (state_q == StOffer) begin
                    state_d = StDummy;
                end else if (state_q == StDummy) begin
                    state_d = StDone;
                end
            end
        end

        if (as_rise && (state_q == StDone)) begin
            cfgout_d = 1'b0;
        end
    end

    // Read ROM: every nibble except er_type/er_size is returned inverted
    always_comb begin
        dout_d = 4'hF;
        case (reg_sel)
            8'h00:   dout_d = (state_q == StDummy) ? ErTypeDummy : ErTypeZ2;
            8'h01:   dout_d = (state_q == StDummy) ? ErSize64K : ErSize2M;
            8'h02:   dout_d = ~PROD_ID[7:4];
            8'h03:   dout_d = ~PROD_ID[3:0];
            8'h04:   dout_d = ~4'b1000;
            8'h05:   dout_d = ~4'b0000;
            8'h08:   dout_d = ~MFG_ID[15:12];
            8'h09:   dout_d = ~MFG_ID[11:8];
            8'h0A:   dout_d = ~MFG_ID[7:4];
            8'h0B:   dout_d = ~MFG_ID[3:0];
            8'h10:   dout_d = ~SERIAL[15:12];
            8'h11:   dout_d = ~SERIAL[11:8];
            8'h12:   dout_d = ~SERIAL[7:4];
            8'h13:   dout_d = ~SERIAL[3:0];
            8'h20:   dout_d = 4'h0;
            8'h21:   dout_d = 4'h0;
            default: dout_d = 4'hF;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= StOffer;
            blk_q    <= 2'd0;
            match_q  <= 8'h00;
            cfg_q    <= 1'b0;
            cfgout_q <= 1'b1;
            dout_q   <= 4'hF;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            match_q  <= match_d;
            cfg_q    <= cfg_d;
            cfgout_q <= cfgout_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: tb/tb_zorro_autoconfig_fsm.sv
// Directed bench for the autoconfig responder: a 4-block and a 1-block instance share stimulus
// and are each checked against a transaction-level model plus literal expectations.
module tb_zorro_autoconfig_fsm;

    localparam logic [15:0] MFG  = 16'h07DB;
    localparam logic [7:0]  PROD = 8'd59;
    localparam logic [15:0] SER  = 16'd421;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:1] addr = '0;
    logic        as_n = 1'b1, uds_n = 1'b1, rw_n = 1'b1;
    logic [3:0]  din = 4'h0;
    logic        cfgin_n = 1'b0;

    logic       cfgout4, cfgout1, conf4, conf1;
    logic [7:0] match4, match1;

    int n_vec = 0;
    int n_err = 0;
    int phase = 0;  // 0 none, 1 idle, 2 read window, 3 write in progress

    always #10 clk = ~clk;

    zorro_autoconfig_fsm_if bus4 ();
    zorro_autoconfig_fsm_if bus1 ();

    assign bus4.ADDR = addr;  assign bus1.ADDR = addr;
    assign bus4.AS_n = as_n;  assign bus1.AS_n = as_n;
    assign bus4.UDS_n = uds_n; assign bus1.UDS_n = uds_n;
    assign bus4.RW_n = rw_n;  assign bus1.RW_n = rw_n;
    assign bus4.DIN = din;    assign bus1.DIN = din;

    zorro_autoconfig_fsm #(.NUM_BLOCKS(4)) dut4 (
        .CLK        (clk),
        .reset      (rst_n),
        .bus        (bus4),
        .CFGIN_n    (cfgin_n),
        .CFGOUT_n   (cfgout4),
        .addr_match (match4),
        .configured (conf4)
    );

    zorro_autoconfig_fsm #(.NUM_BLOCKS(1)) dut1 (
        .CLK        (clk),
        .reset      (rst_n),
        .bus        (bus1),
        .CFGIN_n    (cfgin_n),
        .CFGOUT_n   (cfgout1),
        .addr_match (match1),
        .configured (conf1)
    );

    // Model state per instance: mode 0 offering, 1 dummy, 2 done
    int         nblk [2] = '{4, 1};
    int         m_mode [2];
    int         m_k [2];
    logic [7:0] m_match [2];
    bit         m_cfg [2];
    bit         m_cfgout [2];
    bit         m_dum [2];

    function automatic logic [3:0] rom(input logic [7:0] w, input bit dum);
        case (w)
            8'h00:   rom = dum ? 4'hC : 4'hE;
            8'h01:   rom = dum ? 4'h1 : 4'h6;
            8'h02:   rom = ~PROD[7:4];
            8'h03:   rom = ~PROD[3:0];
            8'h04:   rom = 4'h7;
            8'h05:   rom = 4'hF;
            8'h08:   rom = ~MFG[15:12];
            8'h09:   rom = ~MFG[11:8];
            8'h0A:   rom = ~MFG[7:4];
            8'h0B:   rom = ~MFG[3:0];
            8'h10:   rom = ~SER[15:12];
            8'h11:   rom = ~SER[11:8];
            8'h12:   rom = ~SER[7:4];
            8'h13:   rom = ~SER[3:0];
            8'h20, 8'h21: rom = 4'h0;
            default: rom = 4'hF;
        endcase
    endfunction

    function automatic bit exp_ac(input int d);
        return (addr[23:16] == 8'hE8) && !cfgin_n && (m_mode[d] != 2);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_k[d] = 0; m_match[d] = 8'h00;
            m_cfg[d] = 1'b0; m_cfgout[d] = 1'b1; m_dum[d] = 1'b0;
        end
    endtask

    task automatic model_write(input logic [7:0] pg, input logic [7:0] w, input logic [3:0] dv);
        for (int d = 0; d < 2; d++) begin
            if (pg == 8'hE8 && !cfgin_n && m_mode[d] != 2) begin
                if (w == 8'h24) begin
                    if (m_mode[d] == 0) begin
                        if (dv == 2 || dv == 4 || dv == 6 || dv == 8)
                            m_match[d] = m_match[d] | (8'h03 << (int'(dv) - 2));
                        m_cfg[d] = 1'b1;
                        m_k[d]++;
                        if (m_k[d] == nblk[d]) m_mode[d] = 2;
                    end else begin
                        m_mode[d] = 2;
                    end
                end else if (w == 8'h26) begin
                    if (m_mode[d] == 0) begin
                        m_mode[d] = 1; m_dum[d] = 1'b1;
                    end else begin
                        m_mode[d] = 2;
                    end
                end
            end
        end
    endtask

    task automatic model_as_end();
        for (int d = 0; d < 2; d++) if (m_mode[d] == 2) m_cfgout[d] = 1'b0;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (phase != 0) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] am;
                logic       ad, aco, acf;
                logic [3:0] adout;
                am    = d == 0 ? match4 : match1;
                ad    = d == 0 ? bus4.DOE : bus1.DOE;
                aco   = d == 0 ? cfgout4 : cfgout1;
                acf   = d == 0 ? conf4 : conf1;
                adout = d == 0 ? bus4.DOUT : bus1.DOUT;
                if (phase == 1) begin
                    chk($sformatf("idle_match%0d", d), am, m_match[d]);
                    chk($sformatf("idle_cfgout%0d", d), {7'd0, aco}, {7'd0, m_cfgout[d]});
                    if (!m_dum[d]) chk($sformatf("idle_conf%0d", d), {7'd0, acf}, {7'd0, m_cfg[d]});
                    chk($sformatf("idle_doe%0d", d), {7'd0, ad}, 8'd0);
                end else if (phase == 2) begin
                    chk($sformatf("rd_doe%0d", d), {7'd0, ad}, {7'd0, exp_ac(d)});
                    if (exp_ac(d))
                        chk($sformatf("rd_dout%0d_w%02h", d, addr[8:1]), {4'd0, adout},
                            {4'd0, rom(addr[8:1], m_mode[d] == 1)});
                end else begin
                    chk($sformatf("wr_doe%0d", d), {7'd0, ad}, 8'd0);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        phase = 0;
        as_n = 1'b1; uds_n = 1'b1; rw_n = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_dout", {4'd0, bus4.DOUT}, 8'h0F);
        chk("rst_doe", {7'd0, bus4.DOE}, 8'd0);
        chk("rst_cfgout", {7'd0, cfgout4}, 8'd1);
        chk("rst_match", match4, 8'h00);
        chk("rst_conf", {7'd0, conf4}, 8'd0);
        cyc(2);
        rst_n = 1'b1;
        model_reset();
        cyc(4);
        phase = 1;
    endtask

    task automatic bus_read(input logic [7:0] pg, input logic [7:0] w);
        phase = 0;
        addr = {pg, 7'd0, w}; rw_n = 1'b1;
        cyc(1);
        as_n = 1'b0; uds_n = 1'b0;
        cyc(4);
        phase = 2;
        cyc(3);
        phase = 0;
        as_n = 1'b1; uds_n = 1'b1;
        cyc(4);
        model_as_end();
        phase = 1;
    endtask

    task automatic bus_write(input logic [7:0] pg, input logic [7:0] w, input logic [3:0] dv);
        phase = 0;
        addr = {pg, 7'd0, w}; rw_n = 1'b0; din = dv;
        cyc(1);
        phase = 3;
        as_n = 1'b0;
        cyc(2);
        uds_n = 1'b0;
        cyc(5);
        phase = 0;
        model_write(pg, w, dv);
        as_n = 1'b1; uds_n = 1'b1;
        cyc(4);
        rw_n = 1'b1;
        model_as_end();
        phase = 1;
    endtask

    logic [7:0] rd_list [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08,
                                 8'h09, 8'h0A, 8'h0B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20};

    initial begin
        model_reset();
        cyc(2);
        reset_dut();

        // ROM reads in the offering state
        bus_read(8'hE8, 8'h00);
        chk("lit_type", {4'd0, bus4.DOUT}, 8'h0E);
        bus_read(8'hE8, 8'h01);
        chk("lit_size", {4'd0, bus4.DOUT}, 8'h06);
        bus_read(8'hE8, 8'h03);
        chk("lit_prod_lo", {4'd0, bus4.DOUT}, 8'h04);
        bus_read(8'hE8, 8'h0B);
        chk("lit_mfg_lo", {4'd0, bus4.DOUT}, 8'h04);
        bus_read(8'hE8, 8'h12);
        chk("lit_ser_2", {4'd0, bus4.DOUT}, 8'h05);
        foreach (rd_list[i]) bus_read(8'hE8, rd_list[i]);

        // Four base writes fill the map; single-block instance finishes on the first
        bus_write(8'hE8, 8'h24, 4'd2);
        chk("lit_m4_1", match4, 8'h03);
        chk("lit_m1_1", match1, 8'h03);
        chk("lit_co1_1", {7'd0, cfgout1}, 8'd0);
        bus_write(8'hE8, 8'h24, 4'd4);
        chk("lit_m4_2", match4, 8'h0F);
        bus_write(8'hE8, 8'h24, 4'd6);
        chk("lit_m4_3", match4, 8'h3F);
        chk("lit_co4_3", {7'd0, cfgout4}, 8'd1);
        bus_write(8'hE8, 8'h24, 4'd8);
        chk("lit_m4_4", match4, 8'hFF);
        chk("lit_co4_4", {7'd0, cfgout4}, 8'd0);
        bus_read(8'hE8, 8'h00);

        // Shut-up path into the 64KB dummy board
        reset_dut();
        bus_write(8'hE8, 8'h26, 4'd0);
        bus_read(8'hE8, 8'h00);
        chk("lit_dum_type", {4'd0, bus4.DOUT}, 8'h0C);
        bus_read(8'hE8, 8'h01);
        chk("lit_dum_size", {4'd0, bus4.DOUT}, 8'h01);
        bus_write(8'hE8, 8'h24, 4'd2);
        chk("lit_dum_match", match4, 8'h00);
        chk("lit_dum_co", {7'd0, cfgout4}, 8'd0);
        bus_read(8'hE8, 8'h00);

        // Chain input high: responder stays invisible
        reset_dut();
        cfgin_n = 1'b1;
        cyc(4);
        bus_write(8'hE8, 8'h24, 4'd2);
        bus_read(8'hE8, 8'h00);
        chk("lit_cfgin_match", match4, 8'h00);
        chk("lit_cfgin_co", {7'd0, cfgout4}, 8'd1);
        cfgin_n = 1'b0;
        cyc(4);

        // Single block at $400000, then done and silent
        reset_dut();
        bus_write(8'hE8, 8'h24, 4'd4);
        chk("lit_nb1_match", match1, 8'h0C);
        chk("lit_nb1_conf", {7'd0, conf1}, 8'd1);
        bus_read(8'hE8, 8'h00);
        chk("lit_nb1_co", {7'd0, cfgout1}, 8'd0);

        // Off-page write, duplicate nibble, unmapped nibble, final block
        reset_dut();
        bus_write(8'hE9, 8'h24, 4'd2);
        chk("lit_offpage", match4, 8'h00);
        bus_write(8'hE8, 8'h24, 4'd2);
        bus_write(8'hE8, 8'h24, 4'd2);
        chk("lit_dup", match4, 8'h03);
        bus_write(8'hE8, 8'h24, 4'd3);
        chk("lit_badnib_co", {7'd0, cfgout4}, 8'd1);
        bus_write(8'hE8, 8'h24, 4'd8);
        chk("lit_dup_final", match4, 8'hC3);
        chk("lit_dup_co", {7'd0, cfgout4}, 8'd0);

        // Reset arriving mid-read drops DOE without a clock
        reset_dut();
        phase = 0;
        addr = {8'hE8, 7'd0, 8'h00}; rw_n = 1'b1;
        cyc(1);
        as_n = 1'b0; uds_n = 1'b0;
        cyc(4);
        chk("lit_mid_doe_on", {7'd0, bus4.DOE}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("lit_mid_doe_off", {7'd0, bus4.DOE}, 8'd0);
        as_n = 1'b1; uds_n = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        model_reset();
        cyc(4);
        phase = 1;

        // Reset between UDS fall and AS rise of a base write
        phase = 0;
        addr = {8'hE8, 7'd0, 8'h24}; rw_n = 1'b0; din = 4'd2;
        cyc(1);
        as_n = 1'b0;
        cyc(2);
        uds_n = 1'b0;
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk("lit_wrst_match4", match4, 8'h00);
        chk("lit_wrst_match1", match1, 8'h00);
        chk("lit_wrst_conf", {7'd0, conf4}, 8'd0);
        chk("lit_wrst_co", {7'd0, cfgout4}, 8'd1);
        chk("lit_wrst_dout", {4'd0, bus4.DOUT}, 8'h0F);
        chk("lit_wrst_doe", {7'd0, bus4.DOE}, 8'd0);
        as_n = 1'b1; uds_n = 1'b1; rw_n = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        model_reset();
        cyc(4);
        phase = 1;
        cyc(4);
        bus_read(8'hE8, 8'h00);

        phase = 0;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
